// File: rtl/mlp_layer_engine_if.sv
// Handshake and memory-port bundle between the dense-layer engine, its weight/bias
// ROMs and the layer controller.
interface mlp_layer_engine_if #(
  parameter int NEURONS  = 32,
  parameter int W_ADDR_W = 5,
  parameter int B_ADDR_W = 2
);
  logic                  start;
  logic                  w_ready;
  logic                  b_ready;
  logic [511:0]          x_in;
  logic [W_ADDR_W-1:0]   w_address;
  logic [511:0]          w_data;
  logic [B_ADDR_W-1:0]   b_address;
  logic [63:0]           b_data;
  logic [NEURONS*8-1:0]  y_out;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, w_ready, b_ready, x_in, w_data, b_data,
    output w_address, b_address, y_out, busy, done
  );

  modport master (
    output start, w_ready, b_ready, x_in, w_data, b_data,
    input  w_address, b_address, y_out, busy, done
  );
endinterface

// File: rtl/mlp_layer_engine.sv
// Dense-layer engine: per neuron, 8 MAC cycles over a 64-byte weight row, then
// bias add, optional ReLU and int8 requantisation into y_out.
module mlp_layer_engine #(
  parameter int NEURONS    = 32,
  parameter int W_ADDR_W   = 5,
  parameter int B_ADDR_W   = 2,
  parameter int LANES      = 8,
  parameter int OUT_SHIFT  = 7,
  parameter int BIAS_SHIFT = 7,
  parameter int RELU       = 1
) (
  input  logic clk,
  input  logic rst,
  mlp_layer_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

  state_t                state, state_nx;
  logic [511:0]          x_reg;
  logic signed [23:0]    acc;
  logic [W_ADDR_W-1:0]   n;
  logic [2:0]            c;
  logic [NEURONS*8-1:0]  y_reg;

  logic signed [15:0]    prod;
  logic signed [23:0]    chunk_sum;
  logic signed [7:0]     bias_byte;
  logic signed [23:0]    bias_term;
  logic signed [23:0]    s;
  logic signed [23:0]    r;
  logic [7:0]            y_byte;
  logic                  last_n;
  logic                  accept;

  assign last_n    = (n == W_ADDR_W'(NEURONS - 1));
  assign accept    = (state == IDLE) && bus.start && bus.w_ready && bus.b_ready;
  assign bus.y_out = y_reg;

  // Chunk c covers bytes 8c..8c+7; {c, lane, 000} is the bit offset of that byte.
  always_comb begin
    prod      = '0;
    chunk_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod      = $signed(bus.w_data[{c, 3'(l), 3'b000} +: 8]) *
                  $signed(x_reg[{c, 3'(l), 3'b000} +: 8]);
      chunk_sum = chunk_sum + 24'(prod);
    end
  end

  always_comb begin
    bias_byte = bus.b_data[{n[2:0], 3'b000} +: 8];
    bias_term = 24'(bias_byte) <<< BIAS_SHIFT;
    s         = acc + bias_term;
    r         = s >>> OUT_SHIFT;
    if (RELU != 0 && r < 24'sd0) r = '0;
    if (r > 24'sd127)       y_byte = 8'h7f;
    else if (r < -24'sd128) y_byte = 8'h80;
    else                    y_byte = r[7:0];
  end

  always_comb begin
    state_nx      = state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.w_address = '0;
    bus.b_address = '0;
    case (state)
      IDLE: if (accept) state_nx = MAC;
      MAC: begin
        bus.busy      = 1'b1;
        bus.w_address = n;
        bus.b_address = B_ADDR_W'(n >> 3);
        if (c == 3'd7) state_nx = FIN;
      end
      FIN: begin
        bus.busy      = 1'b1;
        bus.w_address = n;
        bus.b_address = B_ADDR_W'(n >> 3);
        state_nx      = last_n ? DONE : MAC;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x_reg <= '0;
      acc   <= '0;
      n     <= '0;
      c     <= '0;
      y_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          x_reg <= bus.x_in;
          n     <= '0;
          c     <= '0;
          acc   <= '0;
        end
        MAC: begin
          acc <= acc + chunk_sum;
          c   <= c + 3'd1;
        end
        FIN: begin
          y_reg[{n, 3'b000} +: 8] <= y_byte;
          acc <= '0;
          c   <= '0;
          if (!last_n) n <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Bench for mlp_layer_engine: two instances (RELU=1, RELU=0) share stimulus; table
// vectors feed a per-neuron scoreboard popped at the done pulse.
module tb_mlp_layer_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start, w_ready, b_ready;
  logic [511:0]       x_in;
  logic signed [7:0]  wv;
  logic [255:0]       bias_vec;

  mlp_layer_engine_if i1 ();
  mlp_layer_engine_if i0 ();

  assign i1.start   = start;
  assign i1.w_ready = w_ready;
  assign i1.b_ready = b_ready;
  assign i1.x_in    = x_in;
  assign i1.w_data  = {64{wv}};
  assign i1.b_data  = bias_vec[{i1.b_address, 6'b0} +: 64];
  assign i0.start   = start;
  assign i0.w_ready = w_ready;
  assign i0.b_ready = b_ready;
  assign i0.x_in    = x_in;
  assign i0.w_data  = {64{wv}};
  assign i0.b_data  = bias_vec[{i0.b_address, 6'b0} +: 64];

  mlp_layer_engine #(.RELU(1)) u_r1 (.clk(clk), .rst(rst), .bus(i1));
  mlp_layer_engine #(.RELU(0)) u_r0 (.clk(clk), .rst(rst), .bus(i0));

  typedef struct {
    logic signed [7:0] wv;
    logic signed [7:0] xv;
    int                bn;      // neuron carrying a nonzero bias, -1 for none
    logic signed [7:0] bv;
    logic [7:0]        e_oth1;  // expected byte, other neurons, RELU=1
    logic [7:0]        e_oth0;  // expected byte, other neurons, RELU=0
    logic [7:0]        e_b1;    // expected byte, biased neuron, RELU=1
    logic [7:0]        e_b0;    // expected byte, biased neuron, RELU=0
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   q1[$];
  logic [7:0]   q0[$];
  logic [255:0] prev1, prev0, nxt1, nxt0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_window(input string name, input int cycles);
    int bad1 = 0;
    int bad0 = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if ({i1.busy, i1.done} !== 2'b00) bad1++;
      if ({i0.busy, i0.done} !== 2'b00) bad0++;
    end
    check({name, "_r1"}, 256'(bad1), 256'(0));
    check({name, "_r0"}, 256'(bad0), 256'(0));
  endtask

  // Called at a negedge with the engines idle; abort_at != 0 resets mid-run at that cycle.
  task automatic run_layer(input int idx, input bit mid_start, input int abort_at);
    vec_t v;
    int tl1, tl0, dn1, dn0, wa;
    logic e_busy, e_done;
    logic [7:0] e;
    v        = vecs[idx];
    wv       = v.wv;
    x_in     = {64{v.xv}};
    bias_vec = '0;
    if (v.bn >= 0) bias_vec[v.bn*8 +: 8] = v.bv;
    for (int n = 0; n < 32; n++) begin
      nxt1[n*8 +: 8] = (n == v.bn) ? v.e_b1 : v.e_oth1;
      nxt0[n*8 +: 8] = (n == v.bn) ? v.e_b0 : v.e_oth0;
      if (abort_at == 0) begin
        q1.push_back(nxt1[n*8 +: 8]);
        q0.push_back(nxt0[n*8 +: 8]);
      end
    end
    tl1 = 0; tl0 = 0; dn1 = 0; dn0 = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 290; k++) begin
      @(negedge clk);
      start = mid_start && (k == 50);
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_y_r1", i1.y_out, '0);
        check("abort_y_r0", i0.y_out, '0);
        check("abort_ctl_r1", 256'({i1.busy, i1.done, i1.w_address, i1.b_address}), '0);
        check("abort_ctl_r0", 256'({i0.busy, i0.done, i0.w_address, i0.b_address}), '0);
        @(negedge clk);
        rst   = 1'b1;
        prev1 = '0;
        prev0 = '0;
        idle_window("abort_quiet", 20);
        return;
      end
      e_busy = (k <= 288);
      e_done = (k == 289);
      wa     = (k <= 288) ? (k - 1) / 9 : 0;
      if ({i1.busy, i1.done, i1.w_address, i1.b_address} !== {e_busy, e_done, 5'(wa), 2'(wa >> 3)}) tl1++;
      if ({i0.busy, i0.done, i0.w_address, i0.b_address} !== {e_busy, e_done, 5'(wa), 2'(wa >> 3)}) tl0++;
      dn1 += int'(i1.done);
      dn0 += int'(i0.done);
      if (k == 9) begin
        check("hold_r1", i1.y_out, prev1);
        check("hold_r0", i0.y_out, prev0);
      end
      if (k == 10) begin
        check("first_byte_r1", i1.y_out, {prev1[255:8], nxt1[7:0]});
        check("first_byte_r0", i0.y_out, {prev0[255:8], nxt0[7:0]});
      end
      if (k == 289) begin
        for (int n = 0; n < 32; n++) begin
          if (q1.size() == 0 || q0.size() == 0) begin
            check("scoreboard_empty", 256'(1), 256'(0));
          end else begin
            e = q1.pop_front();
            check($sformatf("v%0d_y_r1[%0d]", idx, n), 256'(i1.y_out[n*8 +: 8]), 256'(e));
            e = q0.pop_front();
            check($sformatf("v%0d_y_r0[%0d]", idx, n), 256'(i0.y_out[n*8 +: 8]), 256'(e));
          end
        end
      end
    end
    check($sformatf("v%0d_timeline_r1", idx), 256'(tl1), 256'(0));
    check($sformatf("v%0d_timeline_r0", idx), 256'(tl0), 256'(0));
    check($sformatf("v%0d_done_count_r1", idx), 256'(dn1), 256'(1));
    check($sformatf("v%0d_done_count_r0", idx), 256'(dn0), 256'(1));
    prev1 = nxt1;
    prev0 = nxt0;
  endtask

  initial begin
    vecs[0] = '{8'sd64,   8'sd2,   -1, 8'sd0,   8'h40, 8'h40, 8'h00, 8'h00};
    vecs[1] = '{8'sd127,  8'sd127, -1, 8'sd0,   8'h7f, 8'h7f, 8'h00, 8'h00};
    vecs[2] = '{-8'sd128, 8'sd127, -1, 8'sd0,   8'h00, 8'h80, 8'h00, 8'h00};
    vecs[3] = '{-8'sd1,   8'sd1,   -1, 8'sd0,   8'h00, 8'hff, 8'h00, 8'h00};
    vecs[4] = '{8'sd0,    8'sd7,   11, 8'sd5,   8'h00, 8'h00, 8'h05, 8'h05};
    vecs[5] = '{8'sd0,    8'sd7,   31, -8'sd3,  8'h00, 8'h00, 8'h00, 8'hfd};
    vecs[6] = '{8'sd3,    -8'sd5,  0,  8'sd100, 8'h00, 8'hf8, 8'h5c, 8'h5c};

    rst = 1'b0; start = 1'b0; w_ready = 1'b0; b_ready = 1'b0;
    x_in = '0; wv = '0; bias_vec = '0;
    prev1 = '0; prev0 = '0;
    repeat (3) @(negedge clk);
    check("rst_y_r1", i1.y_out, '0);
    check("rst_y_r0", i0.y_out, '0);
    check("rst_ctl_r1", 256'({i1.busy, i1.done, i1.w_address, i1.b_address}), '0);
    check("rst_ctl_r0", 256'({i0.busy, i0.done, i0.w_address, i0.b_address}), '0);
    rst = 1'b1;

    x_in = {64{8'sd1}}; wv = 8'sd1;
    start = 1'b1; w_ready = 1'b0; b_ready = 1'b1;
    idle_window("no_w_ready", 20);
    w_ready = 1'b1; b_ready = 1'b0;
    idle_window("no_b_ready", 20);
    start = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    check("dropped_start_y", {i1.y_out, i0.y_out} == '0 ? 256'(0) : 256'(1), 256'(0));

    for (int i = 0; i < 7; i++) run_layer(i, i == 2, 0);

    run_layer(0, 1'b0, 100);
    run_layer(6, 1'b0, 0);

    check("scoreboard_drained", 256'(q1.size() + q0.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mlp_layer_engine.md
# mlp_layer_engine

Dense-layer compute engine that sits directly downstream of the weight and bias ROM blocks (W1/B1 for layer 1, W2/B2 for layer 2). On `start` it latches a 64-element int8 input vector and walks every neuron: it addresses one 64-byte weight row and its bias row, then accumulates 8 products per cycle. It adds the scaled bias, applies an optional ReLU and requantises to int8. The resulting output vector is the input vector of the next layer.

## Interface
- `NEURONS`, 32: neurons in the layer; also the number of weight rows.
- `W_ADDR_W`, 5: weight-row address width; must be ≥ clog2(NEURONS).
- `B_ADDR_W`, 2: bias-row address width; each bias row holds 8 biases.
- `LANES`, 8: multiply-accumulate products per cycle; fixed at 8.
- `OUT_SHIFT`, 7: arithmetic right shift applied before saturation.
- `BIAS_SHIFT`, 7: left shift aligning an int8 bias to the accumulator scale.
- `RELU`, 1: 1 clamps negative results to 0; 0 passes signed results.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request a layer evaluation.
- `w_ready` in 1: weight memory initialisation complete.
- `b_ready` in 1: bias memory initialisation complete.
- `x_in` in 512: input vector; byte k = element k, signed int8.
- `w_address` out W_ADDR_W: weight row select.
- `w_data` in 512: weight row, combinational read; byte k pairs with x byte k.
- `b_address` out B_ADDR_W: bias row select.
- `b_data` in 64: bias row, combinational read; byte j = bias of neuron 8·row + j.
- `y_out` out NEURONS·8: result vector, registered; byte n = neuron n.
- `busy` out 1: evaluation in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, MAC, FIN, DONE.
- **IDLE**
  - `start & w_ready & b_ready` at a rising edge: latch `x_in` into `x_reg`; clear neuron index n and chunk index c; clear acc; go to MAC.
  - `start` with either ready low is dropped, not queued.
- **MAC**
  - acc += Σ_{k=8c..8c+7} sext(w_byte k)·sext(x_reg byte k).
  - c increments each cycle; after c = 7, go to FIN.
- **FIN**
  - Compute s = acc + (sext(b_data byte n[2:0]) <<< BIAS_SHIFT).
  - Compute r = s >>> OUT_SHIFT; the shift floors toward −∞.
  - If RELU and r < 0, then r = 0.
  - Saturate r to [−128, 127] and write it to `y_out` byte n.
  - Clear acc and c.
  - If n = NEURONS−1, go to DONE; otherwise n++ and return to MAC.
- **DONE**
  - `done` = 1 for one cycle; go to IDLE.
- Address outputs:
  - `w_address` = n and `b_address` = n >> 3 during MAC and FIN.
  - Both addresses are 0 in IDLE and DONE.
- Datapath widths:
  - acc is 24-bit signed; the worst case |Σ| is 2^20 plus the bias term 2^14, so no overflow is possible.
  - Products are 16-bit signed.
- `start` asserted in any state other than IDLE is ignored.
- `x_in` may change freely after it is latched.
- Ready signals are sampled only in IDLE. The upstream memories hold ready high once it has been asserted.
- Unused input bytes are zero-padded in both the weight rows and `x_in`, so they contribute 0.

## Timing
- **Reset**
  - Reset clears state to IDLE and clears acc, n, c, `x_reg`, `y_out` (all zeros), `busy`, `done`, `w_address` and `b_address`.
  - Reset asserted mid-run aborts the run immediately; there is no `done` pulse and partial results are cleared.
- **Run timing**
  - Start is accepted at edge E0.
  - `busy` is high from E0 until the edge that leaves the last FIN.
  - Each neuron takes 9 cycles: 8 MAC cycles and 1 FIN cycle.
  - `y_out` byte n updates at the edge that ends neuron n's FIN cycle, i.e. E0 + 9(n+1).
  - `done` is high in the cycle following edge E0 + 9·NEURONS; it is low in every other cycle.
  - With defaults, `done` follows edge E0 + 288.
- **Back-to-back runs**
  - A new `start` is accepted at the edge where DONE returns to IDLE, at the earliest.
  - `y_out` retains its previous values until overwritten neuron by neuron.

## Test plan
- **Reset values:** assert `rst` low, then release → all outputs 0 and `busy` = 0. `start` with `w_ready` = 0 → `busy` stays 0 for 20 cycles.
- **Basic dot product:** all weights 64, x all 2, biases 0 → every `y_out` byte = 64 (8192 >>> 7). `done` pulses exactly once, after edge E0 + 288.
- **Saturation:** weights 127, x 127 → every byte = 127. Weights −128, x 127, RELU = 0 → every byte = 0x80.
- **ReLU:** weights −1, x 1, bias 0 → with RELU = 1 every byte = 0x00; with RELU = 0 every byte = 0xFF (−64 >>> 7 = −1).
- **Bias routing:** weights 0; neuron 11's bias = 5 (`b_data` row 1, byte 3), all others 0 → byte 11 = 5, all others 0. `b_address` = 1 while n = 11.
- **Control:** `start` pulsed mid-run is ignored, with no extra `done`. `rst` low at E0 + 100 → IDLE and `y_out` = 0. A new `start` after that completes normally.
